// File: rtl/regf_pkg.sv
// Shared types and defaults for the multi-port register file.
package regf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regf_scoreboard.sv
// Pending-write scoreboard: issue sets busy, write-back clears it, issue wins on a tie.
module regf_scoreboard
  import regf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NWR   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy
);

  localparam logic [AW-1:0] ZeroAddr = AW'(REG_ZERO);

  logic [NREGS-1:0] busy_d, busy_q;
  logic [AW-1:0]    wa [NWR];

  for (genvar j = 0; j < NWR; j++) begin : g_wa
    assign wa[j] = wr_addr[j*AW +: AW];
  end

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wa[j] != ZeroAddr) busy_d[wa[j]] = 1'b0;
    end
    // Applied after clears so a new producer supersedes a retiring one.
    if (issue_en && issue_addr != ZeroAddr) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regf_mp.sv
// Multi-port register file with registered reads and pending-write scoreboard.
// Define REGF_BYPASS_EN to forward same-cycle write data to reads.
module regf_mp
  import regf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  output logic [NREGS-1:0]    busy
);

  localparam logic [AW-1:0] ZeroAddr = AW'(REG_ZERO);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [XLEN-1:0]     mem_d [NREGS];
  logic [NRD*XLEN-1:0] rd_d, rd_q;

  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [AW-1:0]   ra [NRD];

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j] = wr_addr[j*AW +: AW];
    assign wd[j] = wr_data[j*XLEN +: XLEN];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign ra[i] = rd_addr[i*AW +: AW];
  end

  // Ascending port order lets the highest-index writer win.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wa[j] != ZeroAddr) mem_d[wa[j]] = wd[j];
    end
    mem_d[0] = '0;
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_d[i*XLEN +: XLEN] = mem_q[ra[i]];
`ifdef REGF_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wa[j] != ZeroAddr && wa[j] == ra[i]) rd_d[i*XLEN +: XLEN] = wd[j];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      if (rd_en) rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

  regf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rstn       (rstn),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy)
  );

endmodule

// File: tb/tb_regf_mp.sv
// Directed self-checking bench for regf_mp with default parameters (2R/2W, 32x32).
module tb_regf_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic            rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]     rd_data;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [63:0]     wr_data;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic [31:0]     busy;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef REGF_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  regf_mp dut (
    .clk        (clk),
    .rstn       (rstn),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = '0; issue_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en = 1'b1;
    rd_addr = {a1, a0};
  endtask

  function automatic logic [31:0] rd0(); return rd_data[31:0];  endfunction
  function automatic logic [31:0] rd1(); return rd_data[63:32]; endfunction

  initial begin
    rstn = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; issue_addr = '0;
    idle();
    tick(); tick();
    check("reset_rd_data0", rd0(), 32'h0);
    check("reset_busy", busy, 32'h0);
    rstn = 1'b1;

    // Write x5, then reset while also writing/issuing x5.
    wr(0, 5, 32'hDEADBEEF); tick();
    idle(); rstn = 1'b0; wr(0, 5, 32'hCAFEF00D); issue_en = 1'b1; issue_addr = 5; tick();
    idle(); rstn = 1'b1;
    check("rst_busy_ignores_issue", busy, 32'h0);
    rd(5, 5); tick(); idle();
    check("rst_clears_x5", rd0(), 32'h0);

    // Two-port write then read.
    wr(0, 3, 32'h11); wr(1, 4, 32'h22); tick(); idle();
    rd(3, 4); tick(); idle();
    check("rd_x3", rd0(), 32'h11);
    check("rd_x4", rd1(), 32'h22);
    check("write_no_busy", busy, 32'h0);
    rd(4, 4); tick(); idle();
    check("dup_rd0", rd0(), 32'h22);
    check("dup_rd1", rd1(), 32'h22);

    // Same-address conflict and x0 write.
    wr(0, 7, 32'hAA); wr(1, 7, 32'hBB); tick(); idle();
    wr(0, 0, 32'h55); tick(); idle();
    rd(7, 0); tick(); idle();
    check("conflict_x7", rd0(), 32'hBB);
    check("x0_zero", rd1(), 32'h0);

    // Same-cycle forwarding.
    wr(0, 9, 32'h1234); rd(9, 0); tick(); idle();
    check("fwd_x9", rd0(), Bypass ? 32'h1234 : 32'h0);
    wr(0, 10, 32'h1); wr(1, 10, 32'h2); wr(0, 0, 32'h77); rd(10, 0); tick(); idle();
    // Port0 was retargeted to x0, so only port1 writes x10.
    check("fwd_x10_prio", rd0(), Bypass ? 32'h2 : 32'h0);
    check("fwd_x0_blocked", rd1(), 32'h0);
    wr(0, 10, 32'h1); wr(1, 10, 32'h2); rd(10, 9); tick(); idle();
    check("fwd_port1_wins", rd0(), 32'h2);
    check("x9_after", rd1(), 32'h1234);

    // Read hold with rd_en low.
    rd(3, 3); tick(); idle();
    check("hold_pre", rd0(), 32'h11);
    rd_addr = {5'd4, 5'd3}; wr(0, 3, 32'h99); tick(); idle();
    check("hold_1", rd0(), 32'h11);
    tick();
    check("hold_2", rd0(), 32'h11);
    rd(3, 3); tick(); idle();
    check("hold_release", rd0(), 32'h99);

    // Scoreboard.
    issue_en = 1'b1; issue_addr = 6; tick(); idle();
    check("sb_issue6", busy, 32'h0000_0040);
    issue_en = 1'b1; issue_addr = 6; wr(0, 6, 32'h66); tick(); idle();
    check("sb_issue_beats_clear", busy, 32'h0000_0040);
    wr(1, 6, 32'h67); tick(); idle();
    check("sb_clear6", busy, 32'h0);
    issue_en = 1'b1; issue_addr = 0; tick(); idle();
    check("sb_issue_x0", busy, 32'h0);
    issue_en = 1'b1; issue_addr = 11; tick();
    issue_addr = 12; tick();
    issue_addr = 13; tick(); idle();
    check("sb_three_busy", busy, 32'h0000_3800);
    wr(0, 11, 32'h0); wr(1, 12, 32'h0); tick(); idle();
    check("sb_dual_clear", busy, 32'h0000_2000);
    wr(0, 13, 32'h0); wr(1, 13, 32'h0); tick(); idle();
    check("sb_double_clear", busy, 32'h0);
    issue_en = 1'b1; issue_addr = 8; tick(); idle();
    check("sb_issue8", busy, 32'h0000_0100);
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("sb_reset_drops", busy, 32'h0);
    check("rd_reset_mid", rd0(), 32'h0);
    rd(3, 7); tick(); idle();
    check("mem_reset_mid", rd0() | rd1(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
